sram_req_arbiter: RTL and testbench

Parametrised N-channel request arbiter between the CPU core's SRAM-style masters (instruction fetch, data access, future cache/uncached ports) and one shared downstream memory port using the req/addr_ok/data_ok split-transaction handshake. It grants one channel per address phase, tracks up to `MAX_OUTST` accepted requests in issue order, and routes each returned `data_ok`/`rdata` back to the channel that issued it. It sits directly under the CPU top, between the pipeline stages and the bus bridge.

---
 rtl/sram_req_arbiter.sv | 158 +++++++++++++++
 tb/tb_sram_req_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// N-channel req/addr_ok/data_ok arbiter onto one memory port with in-order response routing.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (highest channel wins) instead of round-robin.
module sram_req_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_wr,
  input  logic [2*NUM_CH-1:0]          ch_size,
  input  logic [(DATA_W/8)*NUM_CH-1:0] ch_wstrb,
  input  logic [ADDR_W*NUM_CH-1:0]     ch_addr,
  input  logic [DATA_W*NUM_CH-1:0]     ch_wdata,
  output logic [NUM_CH-1:0]            ch_addr_ok,
  output logic [NUM_CH-1:0]            ch_data_ok,
  output logic [DATA_W-1:0]            ch_rdata,
  output logic                         m_req,
  output logic                         m_wr,
  output logic [1:0]                   m_size,
  output logic [DATA_W/8-1:0]          m_wstrb,
  output logic [ADDR_W-1:0]            m_addr,
  output logic [DATA_W-1:0]            m_wdata,
  input  logic                         m_addr_ok,
  input  logic                         m_data_ok,
  input  logic [DATA_W-1:0]            m_rdata
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int SB    = DATA_W / 8;

  logic              lock_vld;
  logic [CH_W-1:0]   lock_id;
  logic [CH_W-1:0]   gnt;
  logic              gnt_vld;
  logic [CH_W-1:0]   sel;
  logic [CH_W-1:0]   tag_mem [MAX_OUTST];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              full;
  logic              accept;
  logic              pop;
  logic [CH_W-1:0]   head;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    if (lock_vld) begin
      gnt     = lock_id;
      gnt_vld = ch_req[lock_id];
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ch_req[i]) begin
          gnt     = CH_W'(i);
          gnt_vld = 1'b1;
        end
      end
    end
  end
`else
  logic [CH_W-1:0] rr_ptr;

  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt     = '0;
    gnt_vld = 1'b0;
    if (lock_vld) begin
      gnt     = lock_id;
      gnt_vld = ch_req[lock_id];
    end else begin
      // Scan from rr_ptr upward, wrapping; first requester wins.
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        idx = (32'(rr_ptr) + i) % NUM_CH;
        if (!gnt_vld && ch_req[idx]) begin
          gnt     = CH_W'(idx);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (accept)
      rr_ptr <= (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
  end
`endif

  assign full   = (count == (PTR_W+1)'(MAX_OUTST));
  assign m_req  = gnt_vld & ~full & ~reset;
  assign accept = m_req & m_addr_ok;
  assign pop    = m_data_ok & (count != '0) & ~reset;
  assign head   = tag_mem[rd_ptr];
  assign sel    = reset ? '0 : gnt;

  assign m_wr    = ch_wr[sel];
  assign m_size  = ch_size[sel*2 +: 2];
  assign m_wstrb = ch_wstrb[sel*SB +: SB];
  assign m_addr  = ch_addr[sel*ADDR_W +: ADDR_W];
  assign m_wdata = ch_wdata[sel*DATA_W +: DATA_W];

  assign ch_rdata = m_rdata;

  always_comb begin
    ch_addr_ok = '0;
    if (accept)
      ch_addr_ok[gnt] = 1'b1;
  end

  always_comb begin
    ch_data_ok = '0;
    if (pop)
      ch_data_ok[head] = 1'b1;
  end

  // A stalled address phase pins the grant until accepted or the requester withdraws.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_vld <= 1'b0;
      lock_id  <= '0;
    end else if (accept) begin
      lock_vld <= 1'b0;
    end else if (m_req && !m_addr_ok) begin
      lock_vld <= 1'b1;
      lock_id  <= gnt;
    end else if (lock_vld && !ch_req[lock_id]) begin
      lock_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        tag_mem[wr_ptr] <= gnt;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed plus randomized bench for sram_req_arbiter with a queue-based reference model.
module tb_sram_req_arbiter;

  localparam int NUM_CH    = 2;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_OUTST = 4;
  localparam int SB        = DATA_W / 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_wr;
  logic [2*NUM_CH-1:0]      ch_size;
  logic [SB*NUM_CH-1:0]     ch_wstrb;
  logic [ADDR_W*NUM_CH-1:0] ch_addr;
  logic [DATA_W*NUM_CH-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_addr_ok;
  logic [NUM_CH-1:0]        ch_data_ok;
  logic [DATA_W-1:0]        ch_rdata;
  logic                     m_req;
  logic                     m_wr;
  logic [1:0]               m_size;
  logic [SB-1:0]            m_wstrb;
  logic [ADDR_W-1:0]        m_addr;
  logic [DATA_W-1:0]        m_wdata;
  logic                     m_addr_ok;
  logic                     m_data_ok;
  logic [DATA_W-1:0]        m_rdata;

  sram_req_arbiter #(
    .NUM_CH   (NUM_CH),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_req    (ch_req),
    .ch_wr     (ch_wr),
    .ch_size   (ch_size),
    .ch_wstrb  (ch_wstrb),
    .ch_addr   (ch_addr),
    .ch_wdata  (ch_wdata),
    .ch_addr_ok(ch_addr_ok),
    .ch_data_ok(ch_data_ok),
    .ch_rdata  (ch_rdata),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_size    (m_size),
    .m_wstrb   (m_wstrb),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_addr_ok (m_addr_ok),
    .m_data_ok (m_data_ok),
    .m_rdata   (m_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of issuing channels, next-start channel, locked channel (-1 = none).
  int q[$];
  int rr   = 0;
  int lock = -1;
  int  s_g;
  bit  s_acc, s_pop, s_stall, s_rst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    int g;
    bit vld, e_req, e_pop;
    logic [NUM_CH-1:0] e_aok, e_dok;
    @(negedge clk);
    g = 0;
    vld = 1'b0;
    if (lock >= 0) begin
      g   = lock;
      vld = ch_req[lock];
    end else begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      for (int i = NUM_CH - 1; i >= 0; i--)
        if (!vld && ch_req[i]) begin g = i; vld = 1'b1; end
`else
      for (int i = 0; i < NUM_CH; i++)
        if (!vld && ch_req[(rr + i) % NUM_CH]) begin g = (rr + i) % NUM_CH; vld = 1'b1; end
`endif
    end
    e_req = !reset && vld && (q.size() < MAX_OUTST);
    e_aok = '0;
    if (e_req && m_addr_ok) e_aok[g] = 1'b1;
    e_pop = !reset && m_data_ok && (q.size() > 0);
    e_dok = '0;
    if (e_pop) e_dok[q[0]] = 1'b1;
    chk("m_req", m_req, e_req);
    chk("ch_addr_ok", ch_addr_ok, e_aok);
    chk("ch_data_ok", ch_data_ok, e_dok);
    if (e_pop) chk("ch_rdata", ch_rdata, m_rdata);
    if (e_req) begin
      chk("m_addr", m_addr, ch_addr[g*ADDR_W +: ADDR_W]);
      chk("m_wdata", m_wdata, ch_wdata[g*DATA_W +: DATA_W]);
      chk("m_wr", m_wr, ch_wr[g]);
      chk("m_size", m_size, ch_size[g*2 +: 2]);
      chk("m_wstrb", m_wstrb, ch_wstrb[g*SB +: SB]);
    end
    if (reset) begin
      chk("m_addr_rst", m_addr, ch_addr[ADDR_W-1:0]);
      chk("m_wdata_rst", m_wdata, ch_wdata[DATA_W-1:0]);
    end
    s_g     = g;
    s_acc   = e_req && m_addr_ok;
    s_pop   = e_pop;
    s_stall = e_req && !m_addr_ok;
    s_rst   = reset;
  endtask

  task automatic adv();
    @(posedge clk);
    if (s_rst) begin
      q.delete();
      rr   = 0;
      lock = -1;
    end else begin
      if (s_pop) void'(q.pop_front());
      if (s_acc) begin
        q.push_back(s_g);
        rr   = (s_g + 1) % NUM_CH;
        lock = -1;
      end else if (s_stall) begin
        lock = s_g;
      end else if (lock >= 0 && !ch_req[lock]) begin
        lock = -1;
      end
    end
    #1;
  endtask

  task automatic step();
    settle();
    adv();
  endtask

  logic [NUM_CH-1:0] exp_cont [4];

  initial begin
    reset     = 1'b1;
    ch_req    = 2'b11;
    ch_wr     = 2'b00;
    ch_size   = 4'b1010;
    ch_wstrb  = 8'hFF;
    ch_addr   = {32'hA1A1_0004, 32'hA0A0_0000};
    ch_wdata  = {32'h1111_1111, 32'h0000_0000};
    m_addr_ok = 1'b1;
    m_data_ok = 1'b0;
    m_rdata   = '0;
    #1;

    // reset state
    settle();
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_addr_ok", ch_addr_ok, 2'b00);
    chk("rst_m_addr", m_addr, 32'hA0A0_0000);
    adv();
    step();

    // single read on channel 1
    reset = 1'b0;
    ch_req = 2'b10;
    ch_addr[ADDR_W +: ADDR_W] = 32'h1C00_0010;
    settle();
    chk("rd_addr_ok", ch_addr_ok, 2'b10);
    chk("rd_m_addr", m_addr, 32'h1C00_0010);
    adv();
    ch_req = 2'b00;
    m_addr_ok = 1'b0;
    step();
    m_data_ok = 1'b1;
    m_rdata = 32'hDEAD_BEEF;
    settle();
    chk("rd_data_ok", ch_data_ok, 2'b10);
    chk("rd_rdata", ch_rdata, 32'hDEAD_BEEF);
    adv();

    // contention: both request every cycle; first data_ok hits an empty FIFO
`ifdef SRAM_ARB_FIXED_PRIO_EN
    exp_cont = '{2'b10, 2'b10, 2'b10, 2'b10};
`else
    exp_cont = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    ch_req = 2'b11;
    m_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("cont_grant", ch_addr_ok, exp_cont[i]);
      if (i == 0) chk("empty_pop", ch_data_ok, 2'b00);
      adv();
    end
    ch_req = 2'b00;
    step();
    m_data_ok = 1'b0;

    // lock: ch0 stalls three cycles while ch1 joins
    ch_req = 2'b01;
    ch_addr[0 +: ADDR_W] = 32'h1000_0000;
    m_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) ch_req = 2'b11;
      if (i == 3) m_addr_ok = 1'b1;
      settle();
      chk("lock_m_addr", m_addr, 32'h1000_0000);
      chk("lock_addr_ok", ch_addr_ok, (i == 3) ? 2'b01 : 2'b00);
      adv();
    end
    settle();
    chk("post_lock_grant", ch_addr_ok, 2'b10);
    adv();
    ch_req = 2'b00;
    m_data_ok = 1'b1;
    step();
    step();
    m_data_ok = 1'b0;

    // ordering and full: accept 0,1,0,1 then a fifth request must stall
    for (int i = 0; i < 4; i++) begin
      ch_req = (i % 2 == 0) ? 2'b01 : 2'b10;
      settle();
      chk("fill_addr_ok", ch_addr_ok, ch_req);
      adv();
    end
    ch_req = 2'b01;
    settle();
    chk("full_m_req", m_req, 1'b0);
    chk("full_addr_ok", ch_addr_ok, 2'b00);
    adv();
    m_data_ok = 1'b1;
    settle();
    chk("full_pop_m_req", m_req, 1'b0);
    chk("ord_dok0", ch_data_ok, 2'b01);
    adv();
    settle();
    chk("refill_m_req", m_req, 1'b1);
    chk("pushpop_aok", ch_addr_ok, 2'b01);
    chk("ord_dok1", ch_data_ok, 2'b10);
    adv();
    ch_req = 2'b00;
    settle(); chk("ord_dok2", ch_data_ok, 2'b01); adv();
    settle(); chk("ord_dok3", ch_data_ok, 2'b10); adv();
    settle(); chk("ord_dok4", ch_data_ok, 2'b01); adv();
    settle(); chk("drained", ch_data_ok, 2'b00); adv();
    m_data_ok = 1'b0;

    // reset with two outstanding
    ch_req = 2'b11;
    step();
    step();
    reset = 1'b1;
    settle();
    chk("midrst_m_req", m_req, 1'b0);
    chk("midrst_aok", ch_addr_ok, 2'b00);
    adv();
    reset = 1'b0;
    ch_req = 2'b00;
    m_data_ok = 1'b1;
    settle();
    chk("postrst_dok", ch_data_ok, 2'b00);
    adv();

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(63) == 0);
      ch_req    = NUM_CH'($urandom);
      ch_wr     = NUM_CH'($urandom);
      ch_size   = (2*NUM_CH)'($urandom);
      ch_wstrb  = (SB*NUM_CH)'($urandom);
      ch_addr   = {$urandom, $urandom};
      ch_wdata  = {$urandom, $urandom};
      m_addr_ok = ($urandom_range(3) != 0);
      m_data_ok = $urandom_range(1) == 1;
      m_rdata   = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
